// File: rtl/mdu_divide.sv
// mdu_divide: sequential restoring divider (DIV/DIVU), one quotient bit per clock.
// The quotient is committed to LO and the remainder to HI.
// Optional feature macro: MDU_DIV_ZERO_FLAG_EN adds the div_by_zero flag output.
module mdu_divide #(
    parameter int unsigned N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         is_signed,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
`ifdef MDU_DIV_ZERO_FLAG_EN
    ,
    output logic         div_by_zero
`endif
);

    localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [N-1:0] ONE = N'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_d;
    logic          load_c;
    logic          iter_c;
    logic          fix_c;

    logic [N-1:0]  dvd;      // dividend magnitude, shifted out MSB first
    logic [N-1:0]  dvs;      // divisor magnitude
    logic [N-1:0]  rem;      // partial remainder
    logic [N-1:0]  quo;      // quotient, shifted in LSB first
    logic [CW-1:0] count;
    logic          sgn_q;
    logic          sgn_r;

    logic [N-1:0]  a_mag_c;
    logic [N-1:0]  b_mag_c;
    logic [N:0]    r_shift_c;
    logic [N-1:0]  r_diff_c;
    logic          ge_c;

    // Next-state and datapath step selection
    always_comb begin
        state_d = state;
        load_c  = 1'b0;
        iter_c  = 1'b0;
        fix_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    load_c  = 1'b1;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                iter_c = 1'b1;
                if (count == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                fix_c   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Handshake/status outputs, registered from the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            in_ready <= (state_d == S_IDLE);
            busy     <= (state_d != S_IDLE);
            done     <= fix_c;
        end
    end

    // Operand magnitudes and one restoring-division step
    always_comb begin
        a_mag_c   = (is_signed && a[N-1]) ? (~a + ONE) : a;
        b_mag_c   = (is_signed && b[N-1]) ? (~b + ONE) : b;
        r_shift_c = {rem, dvd[N-1]};
        ge_c      = (r_shift_c >= {1'b0, dvs});
        // Only used when r_shift >= dvs, so the true difference fits in N bits
        r_diff_c  = r_shift_c[N-1:0] - dvs;
    end

    // Division datapath and architectural HI/LO
    always_ff @(posedge clock) begin
        if (reset) begin
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            quo   <= '0;
            count <= '0;
            sgn_q <= 1'b0;
            sgn_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (load_c) begin
                dvd   <= a_mag_c;
                dvs   <= b_mag_c;
                rem   <= '0;
                quo   <= '0;
                count <= CW'(N - 1);
                sgn_q <= is_signed & (a[N-1] ^ b[N-1]);
                sgn_r <= is_signed & a[N-1];
            end
            if (iter_c) begin
                dvd   <= {dvd[N-2:0], 1'b0};
                quo   <= {quo[N-2:0], ge_c};
                rem   <= ge_c ? r_diff_c : r_shift_c[N-1:0];
                count <= count - CW'(1);
            end
            if (fix_c) begin
                lo <= sgn_q ? (~quo + ONE) : quo;
                hi <= sgn_r ? (~rem + ONE) : rem;
            end
        end
    end

`ifdef MDU_DIV_ZERO_FLAG_EN
    // Divide-by-zero flag, captured at handshake and held until the next one
    always_ff @(posedge clock) begin
        if (reset) begin
            div_by_zero <= 1'b0;
        end else if (load_c) begin
            div_by_zero <= (b == '0);
        end
    end
`endif

endmodule

// File: tb/tb_mdu_divide.sv
// tb_mdu_divide: directed table-driven bench for mdu_divide plus reset and
// back-to-back sequences.
module tb_mdu_divide;

    localparam int unsigned N = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic         is_signed;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
`ifdef MDU_DIV_ZERO_FLAG_EN
    logic         div_by_zero;
`endif

    mdu_divide #(.N(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .is_signed   (is_signed),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
`ifdef MDU_DIV_ZERO_FLAG_EN
        ,
        .div_by_zero (div_by_zero)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Issue one divide and wait for done; returns observed latency in cycles.
    // While busy, in_valid stays high with scrambled operands, which must be ignored.
    task automatic run_div(input logic sgn, input logic [31:0] va, input logic [31:0] vb,
                           output int lat, output logic ready_ok);
        @(negedge clock);
        is_signed = sgn;
        a         = va;
        b         = vb;
        in_valid  = 1'b1;
        ready_ok  = in_ready;
        @(posedge clock);
        #1;
        a   = ~va;
        b   = vb ^ 32'h0000_0005;
        is_signed = ~sgn;
        lat = 1;
        while (!done && lat < 100) begin
            if (in_ready || !busy) ready_ok = 1'b0;
            @(posedge clock);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        if (done && (!in_ready || busy)) ready_ok = 1'b0;
    endtask

    int   lat;
    logic rok;
    logic saw_done;

    initial begin
        vecs[0]  = '{1'b0, 32'd100,        32'd7,        32'd14,         32'd2,         1'b0};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD,  32'hFFFF_FFFF, 1'b0};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,32'hFFFF_FFFD,  32'd1,         1'b0};
        vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,32'h8000_0000,  32'd0,         1'b0};
        vecs[4]  = '{1'b0, 32'd5,          32'd0,        32'hFFFF_FFFF,  32'd5,         1'b1};
        vecs[5]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,        32'd1,          32'hFFFF_FFFB, 1'b1};
        vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'h10,       32'h0FFF_FFFF,  32'hF,         1'b0};
        vecs[7]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,32'd14,         32'hFFFF_FFFE, 1'b0};
        vecs[8]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,32'd0,          32'h8000_0000, 1'b0};
        vecs[9]  = '{1'b1, 32'd0,          32'd5,        32'd0,          32'd0,         1'b0};
        vecs[10] = '{1'b0, 32'h1234_5678,  32'd1,        32'h1234_5678,  32'd0,         1'b0};

        reset = 1'b1; in_valid = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_hi",       hi,            32'd0);
        check("rst_lo",       lo,            32'd0);
`ifdef MDU_DIV_ZERO_FLAG_EN
        check("rst_dz",       32'(div_by_zero), 32'd0);
`endif

        // Table of directed divides
        for (int i = 0; i < NV; i++) begin
            run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, rok);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd34);
            check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
            check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("v%0d_ready", i), 32'(rok), 32'd1);
`ifdef MDU_DIV_ZERO_FLAG_EN
            check($sformatf("v%0d_dz", i), 32'(div_by_zero), 32'(vecs[i].dz));
`endif
            // HI/LO hold once idle
            repeat (3) @(posedge clock);
            #1;
            check($sformatf("v%0d_lo_hold", i), lo, vecs[i].lo);
        end

        // Reset at cycle 10 of a divide aborts it
        @(negedge clock);
        is_signed = 1'b0; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("abort_hi",       hi,             32'd0);
        check("abort_lo",       lo,             32'd0);
        check("abort_in_ready", 32'(in_ready),  32'd1);
        check("abort_busy",     32'(busy),      32'd0);
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);

        // Back-to-back: second divide issued in the done cycle of the first
        run_div(1'b0, 32'd100, 32'd7, lat, rok);
        check("b2b_first_lo", lo, 32'd14);
        check("b2b_first_hi", hi, 32'd2);
        @(negedge clock);
        check("b2b_done_at_issue", 32'(done), 32'd1);
        is_signed = 1'b0; a = 32'd9; b = 32'd3; in_valid = 1'b1;
        check("b2b_ready_at_issue", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check("b2b_old_lo_held", lo, 32'd14);
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check("b2b_latency", 32'(lat), 32'd34);
        check("b2b_lo",      lo,       32'd3);
        check("b2b_hi",      hi,       32'd0);
        @(posedge clock);
        #1;
        check("b2b_done_pulse", 32'(done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_divide.md
# mdu_divide

Sequential signed/unsigned 32-bit divide unit with architectural HI/LO registers, sitting between the decode/issue stage of the MIPS core and the register-file writeback of MFHI/MFLO. It accepts DIV/DIVU operands through a valid/ready handshake and converts signed operands to magnitudes. It runs a restoring division at one quotient bit per clock, applies MIPS sign rules, and commits the quotient to LO and the remainder to HI. The issue stage stalls on `in_ready` and reads HI/LO directly.

## Interface

**Parameters**

- `N`, 32 — operand/result width; iteration count.

**Ports**

- `clock`  in  1  — rising-edge clock.
- `reset`  in  1  — synchronous, active-high; sampled on the rising edge of `clock`.
- `in_valid`  in  1  — operands and op presented this cycle.
- `in_ready`  out  1  — unit idle; handshake completes when `in_valid` and `in_ready` are both high at an edge.
- `is_signed`  in  1  — 1 = DIV, 0 = DIVU.
- `a`  in  N  — dividend (rs).
- `b`  in  N  — divisor (rt).
- `busy`  out  1  — division in flight.
- `done`  out  1  — one-cycle pulse; HI/LO hold the new result in the same cycle.
- `hi`  out  N  — HI register (remainder).
- `lo`  out  N  — LO register (quotient).
- `div_by_zero`  out  1  — present only with `MDU_DIV_ZERO_FLAG_EN` (see Configuration).

## Operation

**State machine:** IDLE → ITER → FIX → IDLE.

- **IDLE**
  - `in_ready`=1, `busy`=0.
  - On handshake, latch:
    - `sgn_q` = `is_signed` & (a[N-1] ^ b[N-1]).
    - `sgn_r` = `is_signed` & a[N-1].
    - `|a|` into the dividend shift register; `|b|` into the divisor register.
    - Partial remainder R = 0; count = N−1.
  - Magnitude is the two's complement when `is_signed` and MSB=1, else raw.
  - Go to ITER.
- **ITER** (N cycles)
  - Each cycle: R' = {R[N-1:0], dividend bit[count]}, computed N+1 bits wide.
  - If R' ≥ divisor: Q[count]=1 and R = R' − divisor; else Q[count]=0 and R = R'.
  - Decrement count; after the count = 0 cycle, go to FIX.
- **FIX** (1 cycle)
  - LO ← `sgn_q` ? −Q : Q; HI ← `sgn_r` ? −R : R, both truncated to N bits.
  - `done`=1 in the cycle after this edge; go to IDLE.
- **Arithmetic rules**
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - −2^(N−1) / −1 gives LO = 0x80000000 and HI = 0. This wraps with no trap.
- **Divide by zero**
  - No special-casing in the datapath; the result is whatever the algorithm produces.
  - Magnitudes give Q = all ones, R = |a|; the sign rules above are then applied.
- **Hold behaviour**
  - HI/LO change only on the FIX edge or on reset.
  - `in_valid` while not ready is ignored; the operands are not queued.

## Timing

- **Reset values:** `in_ready`=1, `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_by_zero`=0; state IDLE.
- **Latency:** handshake at edge k → ITER on edges k+1..k+N → FIX on edge k+N+1 → `done`=1 and new HI/LO visible during cycle k+N+1 to k+N+2.
  - Total N+2 cycles to `done`.
- **Ready window:** `in_ready` returns high in the same cycle `done` is high.
- **Back-to-back:** a new handshake in the `done` cycle is legal, so throughput is one divide per N+2 cycles.
- **Busy window:** `busy`=1 from the cycle after handshake through the FIX cycle; `busy` and `in_ready` are never both 1.
- **Reset mid-operation:** a reset during ITER or FIX aborts the divide.
  - Next cycle is IDLE, HI/LO = 0, and no `done` pulse.
  - Reset has priority over a simultaneous handshake.

## Configuration

- **`MDU_DIV_ZERO_FLAG_EN` defined:**
  - Port `div_by_zero` exists.
  - It is registered at handshake as (b == 0), held through the divide, and valid while `done`=1.
  - It is cleared at the next handshake or reset.
  - HI/LO results are identical to the macro-undefined build.
- **`MDU_DIV_ZERO_FLAG_EN` undefined:** the port and its register are absent; all other behaviour is unchanged.

## Test plan

- **DIVU:** a=100, b=7 → `done` exactly 34 cycles after handshake; lo=14, hi=2; `in_ready` low during cycles 1..33.
- **DIV:** a=−7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- **DIV:** a=7, b=−2 → lo=0xFFFFFFFD, hi=1.
- **Overflow:** DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- **Divide by zero:**
  - DIVU a=5, b=0 → lo=0xFFFFFFFF, hi=5; `div_by_zero`=1 when the macro is defined.
  - DIV a=−5, b=0 → lo=1, hi=0xFFFFFFFB.
- **Reset and back-to-back:**
  - Start DIVU 100/7, assert `reset` at cycle 10 → no `done` pulse, hi=lo=0, `in_ready`=1 next cycle.
  - Then issue DIVU 9/3 in the `done` cycle of a prior divide → second `done` 34 cycles later with lo=3, hi=0.
